// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversample ratio and
// baud-divider helpers used by the receiver and the tick generator.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } uart_state_e;

   // Clocks per oversample tick; integer division truncates.
   function automatic int unsigned tick_div(input int unsigned clk_freq,
                                            input int unsigned baud);
      return clk_freq / (baud * OVERSAMPLE);
   endfunction

   function automatic int unsigned tick_cnt_w(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every TICK_DIV clocks, with a
// synchronous clear used to phase-align the tick to an event.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned TICK_DIV = 651
) (
   input  logic clk_100m,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = tick_cnt_w(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_100m) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600
) (
   input  logic       clk_100m,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       rx_busy
);

   localparam int unsigned TICK_DIV = tick_div(CLK_FREQ, BAUD);

   uart_state_e state, state_nxt;

   logic       rx_meta, rx_s, rx_prev;
   logic       tick, tick_clr;
   logic       fall, mid_start, mid_bit;
   logic [3:0] scnt;
   logic [2:0] bit_pos;
   logic [7:0] shift_reg;
   logic       par_bad;

   always_ff @(posedge clk_100m) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign fall      = rx_prev & ~rx_s;
   assign mid_start = tick && (scnt == 4'd7);
   assign mid_bit   = tick && (scnt == 4'd15);

   uart_baud_tick #(
      .TICK_DIV(TICK_DIV)
   ) u_baud_tick (
      .clk_100m(clk_100m),
      .rst     (rst),
      .clr     (tick_clr),
      .tick    (tick)
   );

   always_ff @(posedge clk_100m) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tick_clr  = 1'b0;
      case (state)
         IDLE: begin
            if (fall) begin
               state_nxt = START;
               tick_clr  = 1'b1;
            end
         end
         START: begin
            if (mid_start) state_nxt = rx_s ? IDLE : DATA;
         end
         DATA: begin
`ifdef UART_RX_PARITY_EN
            if (mid_bit && bit_pos == 3'd7) state_nxt = PARITY;
`else
            if (mid_bit && bit_pos == 3'd7) state_nxt = STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (mid_bit) state_nxt = STOP;
         end
`endif
         STOP: begin
            if (mid_bit) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit;
   logic pe_q;

   // Even parity: data bits plus parity bit must XOR to zero.
   assign par_bad    = ^{shift_reg, par_bit};
   assign parity_err = pe_q;

   always_ff @(posedge clk_100m) begin
      if (rst) begin
         par_bit <= 1'b0;
         pe_q    <= 1'b0;
      end else begin
         pe_q <= 1'b0;
         if (state == PARITY && mid_bit) par_bit <= rx_s;
         if (state == STOP && mid_bit)   pe_q    <= par_bad;
      end
   end
`else
   assign par_bad    = 1'b0;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk_100m) begin
      if (rst) begin
         scnt       <= '0;
         bit_pos    <= '0;
         shift_reg  <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         // Sample count restarts at the start edge and again at mid start bit.
         if (state == IDLE || (state == START && mid_start)) begin
            scnt <= '0;
         end else if (tick) begin
            scnt <= scnt + 4'd1;
         end
         if (state == IDLE) bit_pos <= '0;
         if (state == DATA && mid_bit) begin
            shift_reg[bit_pos] <= rx_s;
            bit_pos            <= bit_pos + 3'd1;
         end
         if (state == STOP && mid_bit) begin
            if (rx_s && !par_bad) begin
               data_out   <= shift_reg;
               data_valid <= 1'b1;
            end
            frame_err <= ~rx_s;
         end
      end
   end

   assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic
// checked against a frame-level outcome model.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int unsigned CLK_FREQ = 100_000_000;
   localparam int unsigned BAUD     = 1_562_500;          // 4 clocks per tick
   localparam int unsigned BIT      = CLK_FREQ / BAUD;    // 64 clocks per bit
   localparam int unsigned LAT_MIN  = BIT * 19 / 2;       // mid stop bit
   localparam int unsigned LAT_MAX  = LAT_MIN + 2 * (BIT / 16) + 4;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk_100m;
   logic       rst;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       parity_err;
   logic       rx_busy;

   uart_rx #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD    (BAUD)
   ) dut (
      .clk_100m  (clk_100m),
      .rst       (rst),
      .rx        (rx),
      .data_out  (data_out),
      .data_valid(data_valid),
      .frame_err (frame_err),
      .parity_err(parity_err),
      .rx_busy   (rx_busy)
   );

   initial clk_100m = 1'b0;
   always #5 clk_100m = ~clk_100m;

   int unsigned cyc = 0;
   always @(posedge clk_100m) cyc <= cyc + 1;

   // Output monitor: counts pulses and records the latest received byte.
   int unsigned dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, wide_cnt = 0;
   int unsigned busy_bad = 0, busy_rise = 0, last_vcyc = 0;
   logic [7:0]  last_got = '0;
   logic        dv_d = 1'b0, fe_d = 1'b0, pe_d = 1'b0, busy_d = 1'b0;

   always @(negedge clk_100m) begin
      if (data_valid) begin
         dv_cnt++;
         last_got  = data_out;
         last_vcyc = cyc;
         if (rx_busy || !busy_d) busy_bad++;
      end
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
      if ((data_valid && dv_d) || (frame_err && fe_d) || (parity_err && pe_d)) wide_cnt++;
      if (data_valid && frame_err) wide_cnt++;
      if (rx_busy && !busy_d) busy_rise++;
      dv_d   = data_valid;
      fe_d   = frame_err;
      pe_d   = parity_err;
      busy_d = rx_busy;
   end

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [7:0]  last_good = 8'h00;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic lvl, input int unsigned n);
      rx = lvl;
      repeat (n) begin
         @(posedge clk_100m);
         #1;
      end
   endtask

   // Sends one frame and checks its outcome against the frame-level model.
   task automatic frame(input string tag, input logic [7:0] b, input logic stop_lvl,
                        input logic par_flip, input int unsigned bitlen,
                        input int unsigned gap);
      int unsigned dv0, fe0, pe0, w0, bb0, t0, lat;
      logic exp_dv, exp_fe, exp_pe;
      dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt; w0 = wide_cnt; bb0 = busy_bad;
      exp_fe = ~stop_lvl;
      exp_pe = par_flip & PAR_EN;
      exp_dv = stop_lvl & ~exp_pe;
      if (exp_dv) last_good = b;
      t0 = cyc;
      drive(1'b0, bitlen);
      for (int i = 0; i < 8; i++) drive(b[i], bitlen);
      if (PAR_EN) drive(^b ^ par_flip, bitlen);
      drive(stop_lvl, bitlen);
      if (gap != 0) drive(1'b1, gap);
      chk({tag, ".valid"},  dv_cnt - dv0, 32'(exp_dv));
      chk({tag, ".ferr"},   fe_cnt - fe0, 32'(exp_fe));
      chk({tag, ".perr"},   pe_cnt - pe0, 32'(exp_pe));
      chk({tag, ".dout"},   32'(data_out), 32'(last_good));
      chk({tag, ".pulses"}, wide_cnt - w0, 0);
      chk({tag, ".busy"},   32'(rx_busy), 0);
      if (exp_dv && dv_cnt != dv0) begin
         lat = last_vcyc - t0;
         chk({tag, ".byte"},    32'(last_got), 32'(b));
         chk({tag, ".latency"}, 32'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
         chk({tag, ".busyfall"}, busy_bad - bb0, 0);
      end
   endtask

   initial begin
      int unsigned dv0, fe0, pe0, br0;
      logic [7:0]  c3;
      logic [7:0]  rb;
      logic        rs, rp;
      int unsigned rl, rg;

      rx  = 1'b1;
      rst = 1'b1;
      repeat (5) @(posedge clk_100m);
      #1;
      chk("rst.dout",  32'(data_out),   0);
      chk("rst.valid", 32'(data_valid), 0);
      chk("rst.ferr",  32'(frame_err),  0);
      chk("rst.perr",  32'(parity_err), 0);
      chk("rst.busy",  32'(rx_busy),    0);
      rst = 1'b0;
      drive(1'b1, BIT);

      frame("a5", 8'hA5, 1'b1, 1'b0, BIT, BIT);

      // Short low glitch must be rejected at mid start bit.
      dv0 = dv_cnt; fe0 = fe_cnt; br0 = busy_rise;
      drive(1'b0, 18);
      drive(1'b1, 2 * BIT);
      chk("glitch.busy",  busy_rise - br0, 1);
      chk("glitch.valid", dv_cnt - dv0, 0);
      chk("glitch.ferr",  fe_cnt - fe0, 0);
      frame("3c", 8'h3C, 1'b1, 1'b0, BIT, BIT);

      // Low stop bit, then the line stays low as a break.
      frame("7e_ferr", 8'h7E, 1'b0, 1'b0, BIT, 0);
      dv0 = dv_cnt; fe0 = fe_cnt; br0 = busy_rise;
      drive(1'b0, 10 * BIT);
      drive(1'b1, BIT);
      chk("break.valid", dv_cnt - dv0, 0);
      chk("break.ferr",  fe_cnt - fe0, 0);
      chk("break.busy",  busy_rise - br0, 0);
      chk("break.dout",  32'(data_out), 32'(last_good));

      frame("b2b_00", 8'h00, 1'b1, 1'b0, BIT, 0);
      frame("b2b_ff", 8'hFF, 1'b1, 1'b0, BIT, 0);
      frame("b2b_55", 8'h55, 1'b1, 1'b0, BIT, BIT);

      // Reset from bit 4 of 0xC3 until the line is back high.
      c3 = 8'hC3;
      dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
      drive(1'b0, BIT);
      for (int i = 0; i < 4; i++) drive(c3[i], BIT);
      rst = 1'b1;
      for (int i = 4; i < 8; i++) drive(c3[i], BIT);
      if (PAR_EN) drive(^c3, BIT);
      drive(1'b1, BIT / 2);
      rst = 1'b0;
      last_good = 8'h00;
      drive(1'b1, BIT + BIT / 2);
      chk("abort.valid", dv_cnt - dv0, 0);
      chk("abort.ferr",  fe_cnt - fe0, 0);
      chk("abort.perr",  pe_cnt - pe0, 0);
      chk("abort.dout",  32'(data_out), 0);
      chk("abort.busy",  32'(rx_busy), 0);
      frame("81", 8'h81, 1'b1, 1'b0, BIT, BIT);

      if (PAR_EN) begin
         frame("par_ok",  8'h0F, 1'b1, 1'b0, BIT, BIT);
         frame("par_bad", 8'h0F, 1'b1, 1'b1, BIT, BIT);
      end

      for (int n = 0; n < 12; n++) begin
         rb = 8'($urandom);
         rs = ($urandom_range(0, 4) != 0);
         rp = ($urandom_range(0, 3) == 0);
         rl = BIT - 1 + $urandom_range(0, 2);
         rg = rs ? $urandom_range(0, BIT) : $urandom_range(BIT / 2, BIT);
         frame($sformatf("rnd%0d", n), rb, rs, rp, rl, rg);
      end

      drive(1'b1, BIT);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
